branch_reservation_station: RTL and testbench

- In-order issue queue feeding the combinational branch functional unit.
- Accepts dispatched jump/branch ops from the dispatch stage and holds them until their operands arrive.
- Snoops the common data bus (CDB) for pending operands.
- Presents the oldest entry to the FU with ready_to_execute; the FU returns accept.
- This block is the issuing (RS) end of the ready_to_execute/accept handshake.

---
 rtl/branch_reservation_station.sv | 151 +++++++++++++++
 tb/tb_branch_reservation_station.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_reservation_station.sv
// In-order reservation station for the branch unit: buffers dispatched jump/branch ops,
// snoops the CDB for pending operands and presents the oldest entry to the FU.
module branch_reservation_station #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 5
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     dispatch_valid,
   output logic                     dispatch_ready,
   input  logic [TAG_W-1:0]         dispatch_rob_tag,
   input  logic [XLEN-1:0]          dispatch_v1,
   input  logic [XLEN-1:0]          dispatch_v2,
   input  logic                     dispatch_q1_pending,
   input  logic                     dispatch_q2_pending,
   input  logic [TAG_W-1:0]         dispatch_q1,
   input  logic [TAG_W-1:0]         dispatch_q2,
   input  logic [XLEN-1:0]          dispatch_pc_plus_four,
   input  logic [XLEN-1:0]          dispatch_predicted_next_instruction,
   input  logic                     dispatch_jump,
   input  logic                     dispatch_branch,
   input  logic                     dispatch_branch_if_zero,
   input  logic                     dispatch_branch_prediction,
   input  logic                     cdb_valid,
   input  logic [TAG_W-1:0]         cdb_tag,
   input  logic [XLEN-1:0]          cdb_data,
   input  logic                     flush,
   output logic [XLEN-1:0]          v1,
   output logic [XLEN-1:0]          v2,
   output logic [XLEN-1:0]          pc_plus_four,
   output logic [XLEN-1:0]          predicted_next_instruction,
   output logic                     jump,
   output logic                     branch,
   output logic                     branch_if_zero,
   output logic                     branch_prediction,
   output logic [TAG_W-1:0]         rob_tag,
   output logic                     ready_to_execute,
   input  logic                     accept,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FullCount = DEPTH[PW:0];

   typedef struct packed {
      logic             valid;
      logic             q1_pending;
      logic             q2_pending;
      logic [TAG_W-1:0] q1;
      logic [TAG_W-1:0] q2;
      logic [TAG_W-1:0] rob_tag;
      logic [XLEN-1:0]  v1;
      logic [XLEN-1:0]  v2;
      logic [XLEN-1:0]  pc_plus_four;
      logic [XLEN-1:0]  predicted_next_instruction;
      logic             jump;
      logic             branch;
      logic             branch_if_zero;
      logic             branch_prediction;
   } entry_t;

   entry_t          entries [DEPTH];
   entry_t          head_entry;
   entry_t          new_entry;
   logic [PW-1:0]   head_q, tail_q;
   logic [PW:0]     count_q;
   logic            do_push, do_pop;
   logic            bypass1, bypass2;

   assign head_entry       = entries[head_q];
   assign ready_to_execute = head_entry.valid & ~head_entry.q1_pending & ~head_entry.q2_pending;
   assign dispatch_ready   = (count_q < FullCount);
   assign do_push          = dispatch_valid & dispatch_ready;
   assign do_pop           = accept & ready_to_execute;
   assign count            = count_q;

   assign v1                         = head_entry.v1;
   assign v2                         = head_entry.v2;
   assign pc_plus_four               = head_entry.pc_plus_four;
   assign predicted_next_instruction = head_entry.predicted_next_instruction;
   assign jump                       = head_entry.jump;
   assign branch                     = head_entry.branch;
   assign branch_if_zero             = head_entry.branch_if_zero;
   assign branch_prediction          = head_entry.branch_prediction;
   assign rob_tag                    = head_entry.rob_tag;

   // A pending operand whose producer broadcasts in the dispatch cycle is captured directly.
   assign bypass1 = dispatch_q1_pending & cdb_valid & (dispatch_q1 == cdb_tag);
   assign bypass2 = dispatch_q2_pending & cdb_valid & (dispatch_q2 == cdb_tag);

   always_comb begin
      new_entry                            = '0;
      new_entry.valid                      = 1'b1;
      new_entry.rob_tag                    = dispatch_rob_tag;
      new_entry.q1                         = dispatch_q1;
      new_entry.q2                         = dispatch_q2;
      new_entry.q1_pending                 = dispatch_q1_pending & ~bypass1;
      new_entry.q2_pending                 = dispatch_q2_pending & ~bypass2;
      new_entry.v1                         = bypass1 ? cdb_data : dispatch_v1;
      new_entry.v2                         = bypass2 ? cdb_data : dispatch_v2;
      new_entry.pc_plus_four               = dispatch_pc_plus_four;
      new_entry.predicted_next_instruction = dispatch_predicted_next_instruction;
      new_entry.jump                       = dispatch_jump;
      new_entry.branch                     = dispatch_branch;
      new_entry.branch_if_zero             = dispatch_branch_if_zero;
      new_entry.branch_prediction          = dispatch_branch_prediction;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && cdb_valid) begin
               if (entries[i].q1_pending && entries[i].q1 == cdb_tag) begin
                  entries[i].v1         <= cdb_data;
                  entries[i].q1_pending <= 1'b0;
               end
               if (entries[i].q2_pending && entries[i].q2 == cdb_tag) begin
                  entries[i].v2         <= cdb_data;
                  entries[i].q2_pending <= 1'b0;
               end
            end
         end
         // Head and tail slots coincide only when full or empty, so pop and push never collide.
         if (do_pop) begin
            entries[head_q].valid <= 1'b0;
            head_q                <= head_q + PW'(1);
         end
         if (do_push) begin
            entries[tail_q] <= new_entry;
            tail_q          <= tail_q + PW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_reservation_station.sv
// Directed bench: issued ops are checked by a monitor against a scoreboard of expected issues.
module tb_branch_reservation_station;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TAG_W = 5;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  v1;
      logic [XLEN-1:0]  v2;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             dispatch_valid, dispatch_ready;
   logic [TAG_W-1:0] dispatch_rob_tag, dispatch_q1, dispatch_q2;
   logic [XLEN-1:0]  dispatch_v1, dispatch_v2, dispatch_pc_plus_four;
   logic [XLEN-1:0]  dispatch_predicted_next_instruction;
   logic             dispatch_q1_pending, dispatch_q2_pending;
   logic             dispatch_jump, dispatch_branch, dispatch_branch_if_zero;
   logic             dispatch_branch_prediction;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [XLEN-1:0]  cdb_data;
   logic             flush;
   logic [XLEN-1:0]  v1, v2, pc_plus_four, predicted_next_instruction;
   logic             jump, branch, branch_if_zero, branch_prediction;
   logic [TAG_W-1:0] rob_tag;
   logic             ready_to_execute, accept;
   logic [$clog2(DEPTH):0] count;
   logic             accept_en, accept_force;

   exp_t sb[$];
   int   nvec = 0;
   int   nfail = 0;

   always #5 clk = ~clk;
   assign accept = accept_force | (accept_en & ready_to_execute);

   branch_reservation_station #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_rob_tag(dispatch_rob_tag), .dispatch_v1(dispatch_v1), .dispatch_v2(dispatch_v2),
      .dispatch_q1_pending(dispatch_q1_pending), .dispatch_q2_pending(dispatch_q2_pending),
      .dispatch_q1(dispatch_q1), .dispatch_q2(dispatch_q2),
      .dispatch_pc_plus_four(dispatch_pc_plus_four),
      .dispatch_predicted_next_instruction(dispatch_predicted_next_instruction),
      .dispatch_jump(dispatch_jump), .dispatch_branch(dispatch_branch),
      .dispatch_branch_if_zero(dispatch_branch_if_zero),
      .dispatch_branch_prediction(dispatch_branch_prediction),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
      .v1(v1), .v2(v2), .pc_plus_four(pc_plus_four),
      .predicted_next_instruction(predicted_next_instruction),
      .jump(jump), .branch(branch), .branch_if_zero(branch_if_zero),
      .branch_prediction(branch_prediction), .rob_tag(rob_tag),
      .ready_to_execute(ready_to_execute), .accept(accept), .count(count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every handshake that will pop the head must match the oldest expected issue.
   always @(negedge clk) begin
      if (reset_n && ready_to_execute && accept && !flush) begin
         if (sb.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL issue_unexpected: got tag %0d, expected no issue", rob_tag);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("issue_tag", 32'(rob_tag), 32'(e.tag));
            chk("issue_v1", v1, e.v1);
            chk("issue_v2", v2, e.v2);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_issue(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b);
      exp_t e;
      e.tag = tag;
      e.v1  = a;
      e.v2  = b;
      sb.push_back(e);
   endtask

   task automatic set_dispatch(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic p1,
                               input logic [TAG_W-1:0] t1, input logic p2,
                               input logic [TAG_W-1:0] t2);
      dispatch_valid        = 1'b1;
      dispatch_rob_tag      = tag;
      dispatch_v1           = a;
      dispatch_v2           = b;
      dispatch_q1_pending   = p1;
      dispatch_q1           = t1;
      dispatch_q2_pending   = p2;
      dispatch_q2           = t2;
      dispatch_pc_plus_four = a + 32'd4;
   endtask

   task automatic dispatch(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic p1,
                           input logic [TAG_W-1:0] t1, input logic p2,
                           input logic [TAG_W-1:0] t2);
      set_dispatch(tag, a, b, p1, t1, p2, t2);
      step();
      dispatch_valid      = 1'b0;
      dispatch_q1_pending = 1'b0;
      dispatch_q2_pending = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      dispatch_valid = 1'b0; dispatch_rob_tag = '0; dispatch_v1 = '0; dispatch_v2 = '0;
      dispatch_q1_pending = 1'b0; dispatch_q2_pending = 1'b0;
      dispatch_q1 = '0; dispatch_q2 = '0; dispatch_pc_plus_four = '0;
      dispatch_predicted_next_instruction = '0;
      dispatch_jump = 1'b0; dispatch_branch = 1'b1; dispatch_branch_if_zero = 1'b0;
      dispatch_branch_prediction = 1'b0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; flush = 1'b0;
      accept_en = 1'b1; accept_force = 1'b0;

      #12;
      chk("reset_count", 32'(count), 0);
      chk("reset_ready", 32'(ready_to_execute), 0);
      chk("reset_dispatch_ready", 32'(dispatch_ready), 1);
      step();
      reset_n = 1'b1;
      step();

      // Ready dispatch: issuable the cycle after dispatch, popped at the next edge.
      expect_issue(5'd3, 32'h100, 32'h8);
      dispatch(5'd3, 32'h100, 32'h8, 1'b0, 5'd0, 1'b0, 5'd0);
      chk("t1_ready", 32'(ready_to_execute), 1);
      chk("t1_count", 32'(count), 1);
      chk("t1_rob_tag", 32'(rob_tag), 3);
      step();
      chk("t1_count_after_pop", 32'(count), 0);
      chk("t1_ready_after_pop", 32'(ready_to_execute), 0);

      // Pending operand: wrong tag ignored, matching tag resolves one cycle later.
      expect_issue(5'd10, 32'h2000, 32'h4);
      dispatch(5'd10, 32'h0, 32'h4, 1'b1, 5'd7, 1'b0, 5'd0);
      chk("t2_pending_ready", 32'(ready_to_execute), 0);
      cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_data = 32'h999;
      step();
      cdb_valid = 1'b0;
      chk("t2_wrong_tag_ready", 32'(ready_to_execute), 0);
      cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_data = 32'h2000;
      #1;
      chk("t2_no_cdb_issue_bypass", 32'(ready_to_execute), 0);
      step();
      cdb_valid = 1'b0;
      chk("t2_resolved_ready", 32'(ready_to_execute), 1);
      chk("t2_resolved_v1", v1, 32'h2000);
      step();

      // Same-cycle dispatch bypass from the CDB.
      expect_issue(5'd11, 32'h44, 32'h0);
      cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'h44;
      dispatch(5'd11, 32'h0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
      cdb_valid = 1'b0;
      chk("t3_bypass_ready", 32'(ready_to_execute), 1);
      chk("t3_bypass_v1", v1, 32'h44);
      step();

      // Full and wrap: head waits on both operands, younger ready entries stay behind it.
      expect_issue(5'd0, 32'hAA, 32'hAA);
      expect_issue(5'd1, 32'h10, 32'h1);
      expect_issue(5'd2, 32'h20, 32'h2);
      expect_issue(5'd3, 32'h30, 32'h3);
      dispatch(5'd0, 32'h0, 32'h0, 1'b1, 5'd20, 1'b1, 5'd20);
      for (int i = 1; i < 4; i++)
         dispatch(5'(i), 32'(i * 16), 32'(i), 1'b0, 5'd0, 1'b0, 5'd0);
      chk("t4_full_count", 32'(count), 4);
      chk("t4_full_dispatch_ready", 32'(dispatch_ready), 0);
      chk("t4_in_order_block", 32'(ready_to_execute), 0);
      dispatch(5'd31, 32'hDEAD, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
      chk("t4_drop_count", 32'(count), 4);
      cdb_valid = 1'b1; cdb_tag = 5'd20; cdb_data = 32'hAA;
      step();
      cdb_valid = 1'b0;
      step();
      step();
      accept_en = 1'b0;
      chk("t4_after_two_issues", 32'(count), 2);
      expect_issue(5'd4, 32'h40, 32'h4);
      expect_issue(5'd5, 32'h50, 32'h5);
      dispatch(5'd4, 32'h40, 32'h4, 1'b0, 5'd0, 1'b0, 5'd0);
      dispatch(5'd5, 32'h50, 32'h5, 1'b0, 5'd0, 1'b0, 5'd0);
      chk("t4_refill_count", 32'(count), 4);
      accept_en = 1'b1;
      repeat (4) step();
      chk("t4_drained_count", 32'(count), 0);
      chk("t4_scoreboard_empty", 32'(sb.size()), 0);

      // Flush wins over simultaneous dispatch and accept.
      accept_en = 1'b0;
      for (int i = 12; i < 15; i++)
         dispatch(5'(i), 32'(i), 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
      chk("t5_pre_flush_count", 32'(count), 3);
      flush = 1'b1;
      accept_force = 1'b1;
      dispatch(5'd15, 32'h15, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
      flush = 1'b0;
      accept_force = 1'b0;
      chk("t5_flush_count", 32'(count), 0);
      chk("t5_flush_ready", 32'(ready_to_execute), 0);
      chk("t5_flush_dispatch_ready", 32'(dispatch_ready), 1);
      accept_en = 1'b1;
      expect_issue(5'd16, 32'h16, 32'h1);
      dispatch(5'd16, 32'h16, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0);
      step();

      // Asynchronous reset mid-operation with two blocked entries.
      dispatch(5'd17, 32'h77, 32'h0, 1'b1, 5'd2, 1'b0, 5'd0);
      dispatch(5'd18, 32'h78, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
      chk("t6_pre_reset_count", 32'(count), 2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_reset_count", 32'(count), 0);
      chk("t6_reset_ready", 32'(ready_to_execute), 0);
      chk("t6_reset_dispatch_ready", 32'(dispatch_ready), 1);
      chk("t6_reset_v1", v1, 32'h0);
      step();
      reset_n = 1'b1;
      repeat (3) step();
      chk("final_scoreboard_empty", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
